// File: rtl/core_host_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_host_pkg
//  Description : Shared definitions for the core host interface: default
//                geometry constants and the job-sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_host_pkg;

    localparam int c_AW      = 8;     // data-memory address width
    localparam int c_DW      = 8;     // data width
    localparam int c_MAX_CYC = 4096;  // run-phase timeout in clk cycles

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DUMP  = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

endpackage : core_host_pkg
`default_nettype wire

// File: rtl/core_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_host_if
//  Description : Host-side job sequencer for a small core. A job streams
//                load_len bytes from the host into data memory, releases the
//                core from reset and pulses core_req, waits for core_done (or
//                a cycle-count timeout), then streams dump_len bytes from
//                data memory back to the host and pulses finished.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                start, *_base, *_len - job request and region descriptors
//                in_*                 - host-to-memory byte stream
//                out_*                - memory-to-host byte stream
//                mem_*                - data-memory port (owned when mem_sel=1)
//                core_reset/req/done  - core control and completion
//                busy, finished, timeout, run_cycles - job status
//  Revision    : 1.0 - initial release
// ============================================================================
module core_host_if
    import core_host_pkg::*;
#(
    parameter int AW      = c_AW,
    parameter int DW      = c_DW,
    parameter int MAX_CYC = c_MAX_CYC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] load_base,
    input  logic [AW:0]   load_len,
    input  logic [AW-1:0] dump_base,
    input  logic [AW:0]   dump_len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_reset,
    output logic          core_req,
    input  logic          core_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [15:0]   run_cycles
);

    localparam logic [15:0] c_RUN_LIMIT = 16'(MAX_CYC - 1);
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

    state_t          r_state;
    state_t          w_next;

    logic [AW-1:0]   r_load_base;
    logic [AW-1:0]   r_dump_base;
    logic [AW:0]     r_load_len;
    logic [AW:0]     r_dump_len;
    // One extra bit so a full 2^AW-byte region can be counted; only the low
    // AW bits form the address offset, which gives the modulo-2^AW wrap.
    logic [AW:0]     r_idx;
    logic [AW:0]     w_idx_inc;
    logic [15:0]     r_cnt;
    logic [15:0]     r_run_cycles;
    logic            r_timeout;

    logic            w_in_beat;
    logic            w_out_beat;
    logic            w_load_last;
    logic            w_dump_last;
    logic            w_run_exit;
    logic            w_run_timeout;

    assign w_idx_inc     = r_idx + {{AW{1'b0}}, 1'b1};
    assign w_in_beat     = (r_state == ST_LOAD) && in_valid;
    assign w_out_beat    = (r_state == ST_DUMP) && out_ready;
    assign w_load_last   = w_in_beat && (w_idx_inc == r_load_len);
    assign w_dump_last   = w_out_beat && (w_idx_inc == r_dump_len);
    // core_done wins over the timeout when both land on the same cycle.
    assign w_run_timeout = (r_cnt == c_RUN_LIMIT) && !core_done;
    assign w_run_exit    = (r_state == ST_RUN) && (core_done || (r_cnt == c_RUN_LIMIT));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (load_len == '0) ? ST_START : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_load_last) begin
                    w_next = ST_START;
                end
            end
            ST_START: begin
                w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_run_exit) begin
                    w_next = (r_dump_len == '0) ? ST_FIN : ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (w_dump_last) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job descriptor, shared index, run counter and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_base  <= '0;
            r_dump_base  <= '0;
            r_load_len   <= '0;
            r_dump_len   <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_run_cycles <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_load_base <= load_base;
                        r_dump_base <= dump_base;
                        r_load_len  <= load_len;
                        r_dump_len  <= dump_len;
                        r_idx       <= '0;
                        r_timeout   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Index returns to zero on the last beat so DUMP starts clean.
                    if (w_in_beat) begin
                        r_idx <= w_load_last ? '0 : w_idx_inc;
                    end
                end
                ST_START: begin
                    r_cnt <= '0;
                end
                ST_RUN: begin
                    if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                    if (w_run_exit) begin
                        r_run_cycles <= r_cnt;
                        if (w_run_timeout) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (w_out_beat) begin
                        r_idx <= w_dump_last ? '0 : w_idx_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        mem_sel    = 1'b0;
        mem_addr   = '0;
        mem_wr_en  = 1'b0;
        mem_wdata  = '0;
        core_reset = 1'b1;
        core_req   = 1'b0;
        finished   = 1'b0;
        busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                in_ready  = 1'b1;
                mem_sel   = 1'b1;
                mem_addr  = r_load_base + r_idx[AW-1:0];
                mem_wr_en = in_valid;
                mem_wdata = in_data;
            end
            ST_RUN: begin
                core_reset = 1'b0;
                // The counter only reads zero on the first RUN cycle.
                core_req   = (r_cnt == '0);
            end
            ST_DUMP: begin
                // Address moves only on an accepted beat, so the asynchronous
                // read data stays put while the host stalls.
                mem_sel   = 1'b1;
                mem_addr  = r_dump_base + r_idx[AW-1:0];
                out_valid = 1'b1;
                out_data  = mem_rdata;
            end
            ST_FIN: begin
                finished = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign timeout    = r_timeout;
    assign run_cycles = r_run_cycles;

endmodule : core_host_if
`default_nettype wire

// File: tb/tb_core_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_host_if
//  Description : Self-checking bench for core_host_if. A byte-array data
//                memory, a reactive core model and randomized stream drivers
//                surround the DUT; expected writes, dump bytes and run status
//                come from a job-level model of the sequencer's behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_host_if;

    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int TB_MAX = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_len = '0;
    logic [AW-1:0] dump_base = '0;
    logic [AW:0]   dump_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          core_reset;
    logic          core_req;
    logic          core_done = 1'b0;
    logic          busy;
    logic          finished;
    logic          timeout;
    logic [15:0]   run_cycles;

    core_host_if #(.AW(AW), .DW(DW), .MAX_CYC(TB_MAX)) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_base(load_base), .load_len(load_len),
        .dump_base(dump_base), .dump_len(dump_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
        .busy(busy), .finished(finished), .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, asynchronous read.
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       mem_clear = 1'b1;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (mem_sel && mem_wr_en) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus state and observation records.
    logic [7:0]  in_q[$];
    logic [15:0] wr_q[$];
    logic [7:0]  out_q[$];
    int in_ptr = 0, in_mode = 0, or_mode = 2, done_at = 0, tb_run = 0;
    bit last_beat = 0, or_tog = 1, prev_stall = 0;
    logic [7:0] prev_data = '0;
    int req_cnt = 0, fin_cnt = 0, run_obs = 0, viol_cnt = 0;
    int stall_cnt = 0, stall_viol = 0, busy_cnt = 0;

    // Model expectations for the current job.
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_out[$];
    int exp_rc = 0, exp_run = 0;
    bit exp_to = 0;

    // Drive on the falling edge, observe 1 ns later.
    always @(negedge clk) begin
        if (last_beat) in_ptr++;
        last_beat = 0;
        if (in_ptr < in_q.size()) begin
            in_valid = (in_mode == 1) ? 1'b1 : (in_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            in_data  = in_q[in_ptr];
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        case (or_mode)
            0: out_ready = ($urandom_range(0, 2) != 0);
            1: begin
                or_tog    = out_valid ? !or_tog : 1'b1;
                out_ready = or_tog;
            end
            default: out_ready = 1'b1;
        endcase
        if (core_reset) begin
            tb_run    = 0;
            core_done = 1'b0;
        end else begin
            tb_run++;
            run_obs++;
            core_done = (done_at != 0) && (tb_run == done_at);
        end
        #1;
        if (in_valid && in_ready) last_beat = 1;
        if (mem_wr_en) begin
            wr_q.push_back({mem_addr, mem_wdata});
            if (!(in_valid && in_ready && mem_sel)) viol_cnt++;
        end
        if (in_ready && out_valid) viol_cnt++;
        if (prev_stall && out_valid && (out_data !== prev_data)) stall_viol++;
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && !out_ready) stall_cnt++;
        if (out_valid && out_ready) out_q.push_back(out_data);
        if (core_req) req_cnt++;
        if (finished) fin_cnt++;
        if (busy) busy_cnt++;
    end

    // Job-level behaviour: bytes land at base+i (mod 256), the dump reads the
    // memory as it stands after the load, the run lasts until the core's
    // done cycle or TB_MAX cycles, whichever comes first.
    task automatic model_job(input logic [7:0] lb, input int ll, input logic [7:0] db,
                             input int dl, input int da);
        bit done_in_time;
        logic [7:0] a;
        exp_wr.delete();
        for (int i = 0; i < ll; i++) begin
            a = 8'(int'(lb) + i);
            exp_wr.push_back({a, in_q[i]});
            ref_mem[a] = in_q[i];
        end
        exp_out.delete();
        for (int i = 0; i < dl; i++) exp_out.push_back(ref_mem[8'(int'(db) + i)]);
        done_in_time = (da != 0) && (da <= TB_MAX);
        exp_run = done_in_time ? da : TB_MAX;
        exp_rc  = exp_run - 1;
        exp_to  = !done_in_time;
    endtask

    task automatic job_start(input logic [7:0] lb, input int ll, input logic [7:0] db,
                             input int dl, input int da, input int im, input int om, input bit fx);
        in_q.delete();
        for (int i = 0; i < ll; i++) in_q.push_back(fx ? 8'(17 * (i + 1)) : 8'($urandom));
        in_ptr = 0; last_beat = 0;
        wr_q.delete(); out_q.delete();
        req_cnt = 0; fin_cnt = 0; run_obs = 0; viol_cnt = 0;
        stall_cnt = 0; stall_viol = 0; busy_cnt = 0;
        done_at = da; in_mode = im; or_mode = om;
        load_base = lb; load_len = 9'(ll); dump_base = db; dump_len = 9'(dl);
        start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic job_wait(output bit ok);
        for (int c = 0; c < 3000 && fin_cnt == 0; c++) begin
            @(negedge clk); #2;
        end
        ok = (fin_cnt > 0);
        repeat (3) begin @(negedge clk); #2; end
    endtask

    task automatic run_job(input logic [7:0] lb, input int ll, input logic [7:0] db,
                           input int dl, input int da, input int im, input int om,
                           input bit fx, output bit ok);
        job_start(lb, ll, db, dl, da, im, om, fx);
        model_job(lb, ll, db, dl, da);
        job_wait(ok);
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_clear = 1'b1;
        repeat (3) begin @(negedge clk); end
        #2;
        n_checks++;
        if ({busy, finished, timeout, in_ready, out_valid, mem_sel, mem_wr_en, core_req} !== 8'b0) begin
            $display("FAIL reset_flags got=%b exp=%b",
                     {busy, finished, timeout, in_ready, out_valid, mem_sel, mem_wr_en, core_req}, 8'b0);
        end else n_pass++;
        n_checks++;
        if (core_reset !== 1'b1) $display("FAIL reset_core_reset got=%b exp=1", core_reset);
        else n_pass++;
        n_checks++;
        if ({run_cycles, mem_addr, out_data} !== 32'h0) begin
            $display("FAIL reset_values got=%h exp=0", {run_cycles, mem_addr, out_data});
        end else n_pass++;
        reset = 1'b0; mem_clear = 1'b0;
        repeat (2) begin @(negedge clk); end
        #2;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        logic [15:0] e [3];
        logic [15:0] g;
        e[0] = 16'h1011; e[1] = 16'h1122; e[2] = 16'h1233;
        run_job(8'h10, 3, 8'h40, 2, 5, 0, 2, 1'b1, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL basic_done got=%b exp=1", ok); else n_pass++;
        n_checks++;
        if (wr_q.size() != 3) $display("FAIL basic_wr_count got=%0d exp=3", wr_q.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            g = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
            n_checks++;
            if (g !== e[i]) $display("FAIL basic_wr[%0d] got=%h exp=%h", i, g, e[i]); else n_pass++;
        end
        n_checks++;
        if (req_cnt != 1) $display("FAIL basic_core_req got=%0d exp=1", req_cnt); else n_pass++;
        n_checks++;
        if (run_cycles !== 16'd4) $display("FAIL basic_run_cycles got=%0d exp=4", run_cycles); else n_pass++;
        n_checks++;
        if (fin_cnt != 1) $display("FAIL basic_finished got=%0d exp=1", fin_cnt); else n_pass++;
        n_checks++;
        if ({timeout, busy} !== 2'b00) $display("FAIL basic_status got=%b exp=00", {timeout, busy}); else n_pass++;
        n_checks++;
        if (out_q != exp_out) $display("FAIL basic_dump got=%p exp=%p", out_q, exp_out); else n_pass++;
        n_checks++;
        if (viol_cnt != 0) $display("FAIL basic_protocol got=%0d exp=0", viol_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0] ea [4];
        logic [15:0] g, x;
        ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00; ea[3] = 8'h01;
        run_job(8'hFE, 4, 8'hFE, 4, 3, 1, 2, 1'b0, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL wrap_done got=%b exp=1", ok); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            g = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
            x = {ea[i], in_q[i]};
            n_checks++;
            if (g !== x) $display("FAIL wrap_wr[%0d] got=%h exp=%h", i, g, x); else n_pass++;
        end
        n_checks++;
        if (out_q != in_q) $display("FAIL wrap_readback got=%p exp=%p", out_q, in_q); else n_pass++;
        n_checks++;
        if (run_cycles !== 16'd2) $display("FAIL wrap_run_cycles got=%0d exp=2", run_cycles); else n_pass++;
    endtask

    task automatic test_dump_stall();
        bit ok;
        run_job(8'h00, 0, 8'h20, 2, 2, 0, 1, 1'b0, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL stall_done got=%b exp=1", ok); else n_pass++;
        n_checks++;
        if (out_q.size() != 2) $display("FAIL stall_beats got=%0d exp=2", out_q.size()); else n_pass++;
        n_checks++;
        if (out_q != exp_out) $display("FAIL stall_data got=%p exp=%p", out_q, exp_out); else n_pass++;
        n_checks++;
        if (stall_cnt != 2) $display("FAIL stall_cycles got=%0d exp=2", stall_cnt); else n_pass++;
        n_checks++;
        if (stall_viol != 0) $display("FAIL stall_hold got=%0d exp=0", stall_viol); else n_pass++;
        n_checks++;
        if (wr_q.size() != 0) $display("FAIL stall_no_writes got=%0d exp=0", wr_q.size()); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        run_job(8'h50, 2, 8'h60, 3, 0, 0, 0, 1'b0, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL to_done got=%b exp=1", ok); else n_pass++;
        n_checks++;
        if (timeout !== 1'b1) $display("FAIL to_flag got=%b exp=1", timeout); else n_pass++;
        n_checks++;
        if (run_obs != TB_MAX) $display("FAIL to_run_len got=%0d exp=%0d", run_obs, TB_MAX); else n_pass++;
        n_checks++;
        if (run_cycles !== 16'(TB_MAX - 1)) $display("FAIL to_run_cycles got=%0d exp=%0d", run_cycles, TB_MAX - 1); else n_pass++;
        n_checks++;
        if (out_q != exp_out) $display("FAIL to_dump got=%p exp=%p", out_q, exp_out); else n_pass++;
        n_checks++;
        if (fin_cnt != 1) $display("FAIL to_finished got=%0d exp=1", fin_cnt); else n_pass++;
    endtask

    task automatic test_zero_len();
        bit ok;
        run_job(8'h70, 0, 8'h80, 0, 3, 0, 0, 1'b0, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL zero_done got=%b exp=1", ok); else n_pass++;
        n_checks++;
        if (wr_q.size() + out_q.size() != 0) $display("FAIL zero_streams got=%0d exp=0", wr_q.size() + out_q.size()); else n_pass++;
        n_checks++;
        if (busy_cnt != 5) $display("FAIL zero_busy_cycles got=%0d exp=5", busy_cnt); else n_pass++;
        n_checks++;
        if (req_cnt != 1 || run_obs != 3) $display("FAIL zero_run got=%0d/%0d exp=1/3", req_cnt, run_obs); else n_pass++;
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL zero_timeout_cleared got=%b exp=0", timeout); else n_pass++;
        n_checks++;
        if (run_cycles !== 16'd2) $display("FAIL zero_run_cycles got=%0d exp=2", run_cycles); else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int c;
        logic [15:0] g;
        job_start(8'h30, 3, 8'h40, 2, 5, 2, 2, 1'b0);
        // A second request while busy, with a different region, must be ignored.
        start = 1'b1; load_base = 8'h99; load_len = 9'd1;
        @(negedge clk); #2;
        start = 1'b0;
        in_mode = 1;
        c = 0;
        while (wr_q.size() == 0 && c < 20) begin
            @(negedge clk); #2; c++;
        end
        reset = 1'b1;
        @(negedge clk); #2;
        n_checks++;
        if ({busy, core_reset} !== 2'b01) $display("FAIL rst_mid_state got=%b exp=01", {busy, core_reset}); else n_pass++;
        g = (wr_q.size() > 0) ? wr_q[0] : 16'hxxxx;
        n_checks++;
        if (g !== {8'h30, in_q[0]}) $display("FAIL rst_mid_first_wr got=%h exp=%h", g, {8'h30, in_q[0]}); else n_pass++;
        ref_mem[8'h30] = in_q[0];
        reset = 1'b0;
        repeat (4) begin @(negedge clk); end
        #2;
        n_checks++;
        if (wr_q.size() != 1) $display("FAIL rst_mid_writes got=%0d exp=1", wr_q.size()); else n_pass++;
        n_checks++;
        if (fin_cnt != 0 || busy !== 1'b0) $display("FAIL rst_mid_abandon got=%0d/%b exp=0/0", fin_cnt, busy); else n_pass++;
        in_q.delete();
        in_mode = 0;
    endtask

    task automatic test_random();
        bit ok;
        int ll, dl, da, bad;
        for (int j = 0; j < 8; j++) begin
            ll = (j == 3) ? 256 : $urandom_range(0, 10);
            dl = $urandom_range(0, 8);
            da = $urandom_range(0, 20);
            run_job(8'($urandom), ll, 8'($urandom), dl, da, $urandom_range(0, 1),
                    $urandom_range(0, 2), 1'b0, ok);
            n_checks++;
            if (ok !== 1'b1) $display("FAIL rnd%0d_done got=%b exp=1", j, ok); else n_pass++;
            bad = 0;
            if (wr_q.size() != exp_wr.size()) bad++;
            else for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== exp_wr[i]) bad++;
            n_checks++;
            if (bad != 0) $display("FAIL rnd%0d_writes got=%0d bad exp=0 (n=%0d/%0d)", j, bad, wr_q.size(), exp_wr.size()); else n_pass++;
            n_checks++;
            if (out_q != exp_out) $display("FAIL rnd%0d_dump got=%0d beats exp=%0d", j, out_q.size(), exp_out.size()); else n_pass++;
            n_checks++;
            if (run_cycles !== 16'(exp_rc) || timeout !== exp_to)
                $display("FAIL rnd%0d_status got=%0d/%b exp=%0d/%b", j, run_cycles, timeout, exp_rc, exp_to);
            else n_pass++;
            n_checks++;
            if (run_obs != exp_run || req_cnt != 1 || fin_cnt != 1)
                $display("FAIL rnd%0d_run got=%0d/%0d/%0d exp=%0d/1/1", j, run_obs, req_cnt, fin_cnt, exp_run);
            else n_pass++;
            n_checks++;
            if (viol_cnt + stall_viol != 0) $display("FAIL rnd%0d_protocol got=%0d exp=0", j, viol_cnt + stall_viol); else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
        test_reset();
        test_basic();
        test_wrap();
        test_dump_stall();
        test_timeout();
        test_zero_len();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_core_host_if
`default_nettype wire
